// File: rtl/bitwise_logic_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : logic_unit_pkg                                                |
// | Description : Shared types and the bitwise operation function used by the   |
// |               bitwise_logic_unit datapath and its testbench.                |
// |               Contents: op_e operation enum, c_max_width (widest supported  |
// |               operand), apply_op() evaluated at 64 bits so callers slice the|
// |               low WIDTH bits they need.                                     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package logic_unit_pkg;

  localparam int c_max_width = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Evaluated at full 64-bit width; inverting ops set the unused upper bits,
  // which the caller discards by taking only its low WIDTH bits.
  function automatic logic [c_max_width-1:0] apply_op(
    input op_e                    op,
    input logic [c_max_width-1:0] a,
    input logic [c_max_width-1:0] b
  );
    logic [c_max_width-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise_logic_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bitwise_logic_unit_if                                         |
// | Description : Valid/ready operand and result stream of bitwise_logic_unit.  |
// |               Input side : in_valid, in_ready, in_op, in_a, in_b            |
// |               Output side: out_valid, out_ready, out_y, out_zero, out_ones, |
// |                            out_parity, out_popcnt                           |
// |               Status     : op_count (accepted input beats)                  |
// |               master = source/sink around the block, slave = the block.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface bitwise_logic_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int POP_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic [POP_W-1:0] out_popcnt;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity,
           out_popcnt, op_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_ones, out_parity,
           out_popcnt, op_count
  );
endinterface
`default_nettype wire

// File: rtl/bitwise_logic_unit_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage                                                    |
// | Description : One elastic pipeline register: data word plus valid bit.      |
// |               Loads whenever empty or when downstream takes its contents.   |
// |               Ports: clk, rst_n (async active-low), i_valid/o_ready/i_data  |
// |               upstream side, o_valid/i_ready/o_data downstream side.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_stage #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_valid,
  output logic                   o_ready,
  input  wire logic [DATA_W-1:0] i_data,
  output logic                   o_valid,
  input  wire logic              i_ready,
  output logic [DATA_W-1:0]      o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // The stage can take a new word if it is empty or being drained this cycle.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      // Data only moves with a real beat; a bubble leaves the last word in place.
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bitwise_logic_unit                                            |
// | Description : Two-stage pipelined bitwise gate block (AND/NAND/OR/NOR/XOR/  |
// |               XNOR/NOT A/PASS A) with zero/ones/parity/popcount flags.      |
// |               Ports: clk, rst_n (async active-low), bus (slave side of      |
// |               bitwise_logic_unit_if carrying the operand/result streams and |
// |               the accepted-beat counter).                                   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input wire logic           clk,
  input wire logic           rst_n,
  bitwise_logic_unit_if.slave bus
);

  localparam int POP_W  = $clog2(WIDTH + 1);
  localparam int S2_W   = WIDTH + 3 + POP_W;

  logic [c_max_width-1:0] w_a_ext;
  logic [c_max_width-1:0] w_b_ext;
  logic [c_max_width-1:0] w_op_res;
  logic [WIDTH-1:0]       w_y0;
  logic [WIDTH-1:0]       w_y1;
  logic                   w_s1_ready;
  logic                   w_s1_valid;
  logic                   w_s2_ready;
  logic                   w_zero;
  logic                   w_ones;
  logic                   w_parity;
  logic [POP_W-1:0]       w_popcnt;
  logic [S2_W-1:0]        w_s2_in;
  logic [S2_W-1:0]        w_s2_out;
  logic                   w_accept;
  logic [CNT_W-1:0]       r_op_count;

  // Operands widened to the package function's width, result sliced back.
  always_comb begin
    w_a_ext              = '0;
    w_b_ext              = '0;
    w_a_ext[WIDTH-1:0]   = bus.in_a;
    w_b_ext[WIDTH-1:0]   = bus.in_b;
  end

  assign w_op_res = apply_op(op_e'(bus.in_op), w_a_ext, w_b_ext);
  assign w_y0     = w_op_res[WIDTH-1:0];

  generate
    if (WIDTH < c_max_width) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^w_op_res[c_max_width-1:WIDTH];
    end
  endgenerate

  // Stage 1: raw bitwise result.
  pipe_stage #(.DATA_W(WIDTH)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .o_ready (w_s1_ready),
    .i_data  (w_y0),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_y1)
  );

  // Flags are derived from the stage-1 word and registered together with it,
  // so the flags at the output always describe the out_y they travel with.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + POP_W'(w_y1[i]);
    end
  end

  assign w_zero   = ~|w_y1;
  assign w_ones   = &w_y1;
  assign w_parity = ^w_y1;
  assign w_s2_in  = {w_y1, w_zero, w_ones, w_parity, w_popcnt};

  // Stage 2: result plus flags, presented on the output stream.
  pipe_stage #(.DATA_W(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_out)
  );

  assign {bus.out_y, bus.out_zero, bus.out_ones, bus.out_parity, bus.out_popcnt} = w_s2_out;

  // Gated by rst_n so no source sees a ready while the pipe is held in reset.
  assign bus.in_ready = rst_n & w_s1_ready;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Free-running wrap-around count of accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_accept) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign bus.op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bitwise_logic_unit                                         |
// | Description : Self-checking bench for bitwise_logic_unit (WIDTH = 8).       |
// |               Vector table for all ops, scoreboard for streams, hand        |
// |               sequences for reset, backpressure and counter wrap.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bitwise_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bitwise_logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus ();
  bitwise_logic_unit_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(4)) u_dut_cnt4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       ones;
    logic       parity;
    logic [3:0] pop;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   hs_last  = 1'b0;
  bit   hold_pend = 1'b0;
  res_t hold_val;

  function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    case (op)
      3'd0: r.y = a & b;
      3'd1: r.y = ~(a & b);
      3'd2: r.y = a | b;
      3'd3: r.y = ~(a | b);
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~(a ^ b);
      3'd6: r.y = ~a;
      default: r.y = a;
    endcase
    r.zero   = (r.y == 8'h00);
    r.ones   = (r.y == 8'hFF);
    r.parity = ^r.y;
    r.pop    = 4'($countones(r.y));
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.out_y, bus.out_zero, bus.out_ones, bus.out_parity, bus.out_popcnt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and output-hold checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      hs_last   = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_stable", 64'(dut_res()), 64'(hold_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got out_y=%h with no beat in flight, required none", bus.out_y);
        end else begin
          check("scoreboard", 64'(dut_res()), 64'(sb_q.pop_front()));
        end
        n_out++;
      end
      hs_last = bus.in_valid && bus.in_ready;
      if (hs_last) begin
        sb_q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = dut_res();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    if (cyc >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats still in flight, required 0", sb_q.size());
    end
  endtask

  task automatic rand_beat();
    bus.in_op = 3'($urandom_range(0, 7));
    bus.in_a  = 8'($urandom_range(0, 255));
    bus.in_b  = 8'($urandom_range(0, 255));
  endtask

  vec_t vecs[8];

  initial begin
    int out_base;
    int acc;
    int cyc;
    res_t first_exp;

    vecs[0] = '{3'd0, 8'hC5, 8'h3F, {8'h05, 1'b0, 1'b0, 1'b0, 4'd2}};
    vecs[1] = '{3'd1, 8'hC5, 8'h3F, {8'hFA, 1'b0, 1'b0, 1'b0, 4'd6}};
    vecs[2] = '{3'd2, 8'hC5, 8'h3F, {8'hFF, 1'b0, 1'b1, 1'b0, 4'd8}};
    vecs[3] = '{3'd3, 8'hC5, 8'h3F, {8'h00, 1'b1, 1'b0, 1'b0, 4'd0}};
    vecs[4] = '{3'd4, 8'hC5, 8'h3F, {8'hFA, 1'b0, 1'b0, 1'b0, 4'd6}};
    vecs[5] = '{3'd5, 8'hC5, 8'h3F, {8'h05, 1'b0, 1'b0, 1'b0, 4'd2}};
    vecs[6] = '{3'd6, 8'hC5, 8'h3F, {8'h3A, 1'b0, 1'b0, 1'b0, 4'd4}};
    vecs[7] = '{3'd7, 8'hC5, 8'h3F, {8'hC5, 1'b0, 1'b0, 1'b0, 4'd4}};

    bus.in_valid   = 1'b0;
    bus.in_op      = 3'd0;
    bus.in_a       = 8'h00;
    bus.in_b       = 8'h00;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_op     = 3'd0;
    bus4.in_a      = 8'h00;
    bus4.in_b      = 8'h00;
    bus4.out_ready = 1'b1;

    // Reset state.
    #12;
    check("reset_state", 64'({bus.in_ready, bus.out_valid, dut_res(), bus.op_count}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_op_count", 64'(bus.op_count), 64'd0);
    tick();

    // All eight ops, one isolated beat each, result two cycles after input.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = vecs[i].op;
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check($sformatf("op%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("op%0d_result", i), 64'(dut_res()), 64'(vecs[i].exp));
    end
    drain();
    check("table_op_count", 64'(bus.op_count), 64'd8);

    // Full-rate stream of 20 beats.
    out_base = n_out;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      rand_beat();
      tick();
    end
    drain();
    check("fullrate_outputs", 64'(n_out - out_base), 64'd20);
    check("fullrate_op_count", 64'(bus.op_count), 64'd28);

    // Backpressure: two beats fill the pipe, third is held by the source.
    out_base = n_out;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op = 3'd4; bus.in_a = 8'h96; bus.in_b = 8'h0F;
    first_exp = model(3'd4, 8'h96, 8'h0F);
    tick();
    bus.in_op = 3'd1; bus.in_a = 8'hFF; bus.in_b = 8'hFF;
    tick();
    bus.in_op = 3'd6; bus.in_a = 8'h01; bus.in_b = 8'h00;
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    repeat (3) tick();
    check("bp_still_full", 64'(bus.in_ready), 64'd0);
    check("bp_first_stable", 64'(dut_res()), 64'(first_exp));
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", 64'(bus.in_ready), 64'd1);
    tick();
    drain();
    check("bp_outputs", 64'(n_out - out_base), 64'd3);

    // Reset in the middle of a stream.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_state", 64'({bus.in_ready, bus.out_valid, dut_res(), bus.op_count}), 64'd0);
    sb_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_release_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_release_count", 64'(bus.op_count), 64'd0);
    tick();

    // Random in_valid / out_ready over 1000 accepted beats.
    out_base = n_out;
    acc = 0;
    cyc = 0;
    bus.in_valid = 1'b0;
    while (cyc < 20000) begin
      if (bus.in_valid && hs_last) begin
        acc++;
        bus.in_valid = 1'b0;
      end
      if (acc == 1000) break;
      if (!bus.in_valid) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        rand_beat();
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    if (acc != 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL random_timeout: got %0d beats accepted, required 1000", acc);
    end
    drain();
    check("random_outputs", 64'(n_out - out_base), 64'd1000);
    check("random_op_count", 64'(bus.op_count), 64'd1000);

    // 4-bit counter wraps after 16 beats.
    bus4.in_valid = 1'b1;
    repeat (17) tick();
    bus4.in_valid = 1'b0;
    tick();
    check("cnt4_wrap", 64'(bus4.op_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
